// File: rtl/reloj_bcd.sv
// -----------------------------------------------------------------------------
// reloj_bcd
//   Time-of-day counter driving the BCD HH:MM digits b3..b0 used by the alarm
//   comparator. A prescaler divides reloj1 down to a one-per-second tick. An
//   internal BCD seconds count carries into minutes, and minutes carry into
//   hours. In set mode (ajuste=1) time is frozen, and rising edges on the
//   push-button inputs step minutes and hours independently.
//
//   Optional feature macro: FORMATO_12H_EN
//     When defined, hours count 12,1..11 and pm toggles on 11->12.
//     When undefined, hours count 00..23 and pm is tied to 0.
//
// Parameters
//   DIV        reloj1 cycles per second tick (>= 2)
//   DIV_W      prescaler width, must hold DIV-1
//
// Ports
//   reloj1     in   FPGA clock, all logic on posedge
//   reinicio_n in   asynchronous active-low reset
//   ajuste     in   set mode: 1 = time frozen, buttons active
//   inc_min    in   minute button, level, synchronous to reloj1
//   inc_hora   in   hour button, level, synchronous to reloj1
//   b0..b3     out  BCD minutes units/tens, hours units/tens
//   pm         out  PM flag (12 h build only, otherwise 0)
//   pulso_seg  out  one-cycle pulse on each second tick
// -----------------------------------------------------------------------------
module reloj_bcd #(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26
) (
    input  logic       reloj1,
    input  logic       reinicio_n,
    input  logic       ajuste,
    input  logic       inc_min,
    input  logic       inc_hora,
    output logic [3:0] b0,
    output logic [3:0] b1,
    output logic [3:0] b2,
    output logic [3:0] b3,
    output logic       pm,
    output logic       pulso_seg
);

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(DIV - 1);

`ifdef FORMATO_12H_EN
    localparam logic [3:0] HORA_T_RST = 4'd1;
    localparam logic [3:0] HORA_U_RST = 4'd2;
`else
    localparam logic [3:0] HORA_T_RST = 4'd0;
    localparam logic [3:0] HORA_U_RST = 4'd0;
`endif

    logic [DIV_W-1:0] presc_q, presc_d;
    logic [3:0]       seg_u_q, seg_u_d;
    logic [3:0]       seg_t_q, seg_t_d;
    logic [3:0]       min_u_q, min_u_d;
    logic [3:0]       min_t_q, min_t_d;
    logic [3:0]       hora_u_q, hora_u_d;
    logic [3:0]       hora_t_q, hora_t_d;
    logic             pulso_q, pulso_d;
    logic             min_prev_q, min_prev_d;
    logic             hora_prev_q, hora_prev_d;
`ifdef FORMATO_12H_EN
    logic             pm_q, pm_d;
    logic             hora_flip;
`endif

    logic [3:0] min_u_inc, min_t_inc;
    logic       min_wrap;
    logic [3:0] hora_u_inc, hora_t_inc;
    logic       tick;
    logic       min_rise, hora_rise;

    // Next value of minutes and hours as if stepped by one. Shared by the
    // tick carry path and the set-mode buttons so both wrap identically.
    always_comb begin
        min_u_inc  = min_u_q + 4'd1;
        min_t_inc  = min_t_q;
        min_wrap   = 1'b0;
        hora_u_inc = hora_u_q + 4'd1;
        hora_t_inc = hora_t_q;
`ifdef FORMATO_12H_EN
        hora_flip  = 1'b0;
`endif

        if (min_u_q == 4'd9) begin
            min_u_inc = 4'd0;
            if (min_t_q == 4'd5) begin
                min_t_inc = 4'd0;
                min_wrap  = 1'b1;
            end else begin
                min_t_inc = min_t_q + 4'd1;
            end
        end

`ifdef FORMATO_12H_EN
        // 12 -> 01 keeps the meridian; 11 -> 12 crosses noon/midnight.
        if (hora_t_q == 4'd1 && hora_u_q == 4'd2) begin
            hora_t_inc = 4'd0;
            hora_u_inc = 4'd1;
        end else if (hora_t_q == 4'd1 && hora_u_q == 4'd1) begin
            hora_t_inc = 4'd1;
            hora_u_inc = 4'd2;
            hora_flip  = 1'b1;
        end else if (hora_u_q == 4'd9) begin
            hora_t_inc = hora_t_q + 4'd1;
            hora_u_inc = 4'd0;
        end
`else
        if (hora_t_q == 4'd2 && hora_u_q == 4'd3) begin
            hora_t_inc = 4'd0;
            hora_u_inc = 4'd0;
        end else if (hora_u_q == 4'd9) begin
            hora_t_inc = hora_t_q + 4'd1;
            hora_u_inc = 4'd0;
        end
`endif
    end

    // Main next-state logic: set mode freezes the prescaler and seconds and
    // lets button edges step the digits; run mode counts and ripples carries.
    always_comb begin
        presc_d     = presc_q;
        seg_u_d     = seg_u_q;
        seg_t_d     = seg_t_q;
        min_u_d     = min_u_q;
        min_t_d     = min_t_q;
        hora_u_d    = hora_u_q;
        hora_t_d    = hora_t_q;
        pulso_d     = 1'b0;
        min_prev_d  = inc_min;
        hora_prev_d = inc_hora;
`ifdef FORMATO_12H_EN
        pm_d        = pm_q;
`endif

        // Edge registers track the buttons in both modes, so a button that is
        // already held when set mode is entered does not register a press.
        min_rise  = inc_min & ~min_prev_q;
        hora_rise = inc_hora & ~hora_prev_q;
        tick      = ~ajuste & (presc_q == PRESC_MAX);

        if (ajuste) begin
            presc_d = '0;
            seg_u_d = 4'd0;
            seg_t_d = 4'd0;
            if (min_rise) begin
                min_u_d = min_u_inc;
                min_t_d = min_t_inc;
            end
            if (hora_rise) begin
                hora_u_d = hora_u_inc;
                hora_t_d = hora_t_inc;
`ifdef FORMATO_12H_EN
                if (hora_flip) begin
                    pm_d = ~pm_q;
                end
`endif
            end
        end else if (tick) begin
            presc_d = '0;
            pulso_d = 1'b1;
            if (seg_u_q == 4'd9) begin
                seg_u_d = 4'd0;
                if (seg_t_q == 4'd5) begin
                    seg_t_d = 4'd0;
                    min_u_d = min_u_inc;
                    min_t_d = min_t_inc;
                    if (min_wrap) begin
                        hora_u_d = hora_u_inc;
                        hora_t_d = hora_t_inc;
`ifdef FORMATO_12H_EN
                        if (hora_flip) begin
                            pm_d = ~pm_q;
                        end
`endif
                    end
                end else begin
                    seg_t_d = seg_t_q + 4'd1;
                end
            end else begin
                seg_u_d = seg_u_q + 4'd1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge reloj1 or negedge reinicio_n) begin
        if (!reinicio_n) begin
            presc_q     <= '0;
            seg_u_q     <= 4'd0;
            seg_t_q     <= 4'd0;
            min_u_q     <= 4'd0;
            min_t_q     <= 4'd0;
            hora_u_q    <= HORA_U_RST;
            hora_t_q    <= HORA_T_RST;
            pulso_q     <= 1'b0;
            min_prev_q  <= 1'b0;
            hora_prev_q <= 1'b0;
`ifdef FORMATO_12H_EN
            pm_q        <= 1'b0;
`endif
        end else begin
            presc_q     <= presc_d;
            seg_u_q     <= seg_u_d;
            seg_t_q     <= seg_t_d;
            min_u_q     <= min_u_d;
            min_t_q     <= min_t_d;
            hora_u_q    <= hora_u_d;
            hora_t_q    <= hora_t_d;
            pulso_q     <= pulso_d;
            min_prev_q  <= min_prev_d;
            hora_prev_q <= hora_prev_d;
`ifdef FORMATO_12H_EN
            pm_q        <= pm_d;
`endif
        end
    end

    assign b0        = min_u_q;
    assign b1        = min_t_q;
    assign b2        = hora_u_q;
    assign b3        = hora_t_q;
    assign pulso_seg = pulso_q;
`ifdef FORMATO_12H_EN
    assign pm        = pm_q;
`else
    assign pm        = 1'b0;
`endif

endmodule

// File: tb/tb_reloj_bcd.sv
// -----------------------------------------------------------------------------
// tb_reloj_bcd
//   Self-checking bench for reloj_bcd with DIV=4. A table of set-mode button
//   vectors is applied first, followed by hand-written multi-cycle sequences:
//   asynchronous reset, free run, midnight/noon rollover, held buttons and
//   simultaneous button edges. Handles both the 24 h and 12 h builds
//   (FORMATO_12H_EN).
// -----------------------------------------------------------------------------
module tb_reloj_bcd;

    localparam int DIV = 4;

`ifdef FORMATO_12H_EN
    localparam logic [3:0] RST_HT = 4'd1;
    localparam logic [3:0] RST_HU = 4'd2;
`else
    localparam logic [3:0] RST_HT = 4'd0;
    localparam logic [3:0] RST_HU = 4'd0;
`endif

    logic       reloj1;
    logic       reinicio_n;
    logic       ajuste;
    logic       inc_min;
    logic       inc_hora;
    logic [3:0] b0, b1, b2, b3;
    logic       pm;
    logic       pulso_seg;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        logic       aj;
        logic       im;
        logic       ih;
        int         ncyc;
        logic [3:0] e3, e2, e1, e0;
        logic       ep;
    } vec_t;

    vec_t vecs[10];

    reloj_bcd #(.DIV(DIV), .DIV_W(3)) dut (
        .reloj1    (reloj1),
        .reinicio_n(reinicio_n),
        .ajuste    (ajuste),
        .inc_min   (inc_min),
        .inc_hora  (inc_hora),
        .b0        (b0),
        .b1        (b1),
        .b2        (b2),
        .b3        (b3),
        .pm        (pm),
        .pulso_seg (pulso_seg)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        reloj1 = 1'b0;
        forever #5 reloj1 = ~reloj1;
    end

    // Advance n active edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge reloj1);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e3, input logic [3:0] e2,
                               input logic [3:0] e1, input logic [3:0] e0, input logic ep);
        compared++;
        if ({b3, b2, b1, b0, pulso_seg} !== {e3, e2, e1, e0, ep}) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d%0d:%0d%0d pulso=%b, want %0d%0d:%0d%0d pulso=%b",
                     name, b3, b2, b1, b0, pulso_seg, e3, e2, e1, e0, ep);
        end
    endtask

    task automatic checkPm(input string name, input logic ep);
        compared++;
        if (pm !== ep) begin
            mismatched++;
            $display("[TB] FAIL %s: pm got %b, want %b", name, pm, ep);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ajuste   = v.aj;
        inc_min  = v.im;
        inc_hora = v.ih;
        step(v.ncyc);
    endtask

    task automatic doReset();
        ajuste     = 1'b0;
        inc_min    = 1'b0;
        inc_hora   = 1'b0;
        reinicio_n = 1'b0;
        step(1);
        reinicio_n = 1'b1;
    endtask

    // Enter set mode and press each button the given number of times.
    task automatic setTime(input int hp, input int mp);
        ajuste = 1'b1;
        for (int i = 0; i < hp; i++) begin
            inc_hora = 1'b1;
            step(1);
            inc_hora = 1'b0;
            step(1);
        end
        for (int i = 0; i < mp; i++) begin
            inc_min = 1'b1;
            step(1);
            inc_min = 1'b0;
            step(1);
        end
    endtask

    initial begin
        int pulses;

        vecs[0] = '{"set_min_rise",        1'b1, 1'b1, 1'b0, 1, RST_HT, RST_HU, 4'd0, 4'd1, 1'b0};
        vecs[1] = '{"set_min_held",        1'b1, 1'b1, 1'b0, 3, RST_HT, RST_HU, 4'd0, 4'd1, 1'b0};
        vecs[2] = '{"set_min_release",     1'b1, 1'b0, 1'b0, 1, RST_HT, RST_HU, 4'd0, 4'd1, 1'b0};
        vecs[3] = '{"set_hora_rise",       1'b1, 1'b0, 1'b1, 1, 4'd0,   4'd1,   4'd0, 4'd1, 1'b0};
        vecs[4] = '{"set_min_hora_held",   1'b1, 1'b1, 1'b1, 1, 4'd0,   4'd1,   4'd0, 4'd2, 1'b0};
        vecs[5] = '{"set_release",         1'b1, 1'b0, 1'b0, 1, 4'd0,   4'd1,   4'd0, 4'd2, 1'b0};
        vecs[6] = '{"run_buttons_ignored", 1'b0, 1'b1, 1'b1, 1, 4'd0,   4'd1,   4'd0, 4'd2, 1'b0};
        vecs[7] = '{"held_into_ajuste",    1'b1, 1'b1, 1'b1, 2, 4'd0,   4'd1,   4'd0, 4'd2, 1'b0};
        vecs[8] = '{"set_release2",        1'b1, 1'b0, 1'b0, 1, 4'd0,   4'd1,   4'd0, 4'd2, 1'b0};
        vecs[9] = '{"set_both_rise",       1'b1, 1'b1, 1'b1, 1, 4'd0,   4'd2,   4'd0, 4'd3, 1'b0};

        reinicio_n = 1'b1;
        ajuste     = 1'b0;
        inc_min    = 1'b0;
        inc_hora   = 1'b0;
        #2;
        doReset();
        checkOutput("reset_state", RST_HT, RST_HU, 4'd0, 4'd0, 1'b0);
        checkPm("reset_pm", 1'b0);

        // Table-driven set-mode vectors.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].e3, vecs[i].e2, vecs[i].e1, vecs[i].e0, vecs[i].ep);
        end
        checkPm("table_pm", 1'b0);

        // Async reset mid-count at 13:27 (01:27 pm in the 12 h build) while pulso_seg is high.
        doReset();
        setTime(13, 27);
        ajuste = 1'b0;
`ifdef FORMATO_12H_EN
        checkOutput("pre_reset_time", 4'd0, 4'd1, 4'd2, 4'd7, 1'b0);
`else
        checkOutput("pre_reset_time", 4'd1, 4'd3, 4'd2, 4'd7, 1'b0);
`endif
        step(4);
`ifdef FORMATO_12H_EN
        checkOutput("pre_reset_pulse", 4'd0, 4'd1, 4'd2, 4'd7, 1'b1);
`else
        checkOutput("pre_reset_pulse", 4'd1, 4'd3, 4'd2, 4'd7, 1'b1);
`endif
        #2;
        reinicio_n = 1'b0;
        #1;
        checkOutput("async_reset", RST_HT, RST_HU, 4'd0, 4'd0, 1'b0);
        checkPm("async_reset_pm", 1'b0);
        step(1);
        reinicio_n = 1'b1;

        // Free run from reset: 240 cycles give 60 pulses and one minute.
        doReset();
        pulses = 0;
        for (int i = 0; i < 240; i++) begin
            step(1);
            if (pulso_seg === 1'b1) pulses++;
        end
        checkCount("free_run_pulses", pulses, 60);
        checkOutput("free_run_time", RST_HT, RST_HU, 4'd0, 4'd1, 1'b1);

        // Held minute button at 07:59 steps once, no hour carry.
        doReset();
        setTime(7, 59);
        checkOutput("set_0759", 4'd0, 4'd7, 4'd5, 4'd9, 1'b0);
        inc_min = 1'b1;
        step(10);
        checkOutput("held_min_wrap", 4'd0, 4'd7, 4'd0, 4'd0, 1'b0);
        inc_min = 1'b0;
        step(1);

        // Simultaneous edges at 09:15 in set mode.
        doReset();
        setTime(9, 15);
        inc_min  = 1'b1;
        inc_hora = 1'b1;
        step(1);
        checkOutput("both_edges_set", 4'd1, 4'd0, 4'd1, 4'd6, 1'b0);
        inc_min  = 1'b0;
        inc_hora = 1'b0;
        step(1);

        // Same stimulus in run mode leaves 09:15; pulses come only from the prescaler.
        doReset();
        setTime(9, 15);
        ajuste   = 1'b0;
        inc_min  = 1'b1;
        inc_hora = 1'b1;
        step(3);
        checkOutput("both_edges_run", 4'd0, 4'd9, 4'd1, 4'd5, 1'b0);
        step(1);
        checkOutput("run_first_tick", 4'd0, 4'd9, 4'd1, 4'd5, 1'b1);
        inc_min  = 1'b0;
        inc_hora = 1'b0;

`ifdef FORMATO_12H_EN
        // 11:59 -> 12:00 toggles pm; 12:59 -> 01:00 leaves it.
        doReset();
        setTime(11, 59);
        checkOutput("set_1159", 4'd1, 4'd1, 4'd5, 4'd9, 1'b0);
        checkPm("pm_1159", 1'b0);
        ajuste = 1'b0;
        step(240);
        checkOutput("noon_roll", 4'd1, 4'd2, 4'd0, 4'd0, 1'b1);
        checkPm("pm_noon", 1'b1);
        setTime(0, 59);
        checkOutput("set_1259", 4'd1, 4'd2, 4'd5, 4'd9, 1'b0);
        ajuste = 1'b0;
        step(240);
        checkOutput("one_roll", 4'd0, 4'd1, 4'd0, 4'd0, 1'b1);
        checkPm("pm_one", 1'b1);
`else
        // 23:59 -> 00:00 on the 60th tick, all digits in the same cycle.
        doReset();
        setTime(23, 59);
        checkOutput("set_2359", 4'd2, 4'd3, 4'd5, 4'd9, 1'b0);
        ajuste = 1'b0;
        step(239);
        checkOutput("pre_midnight", 4'd2, 4'd3, 4'd5, 4'd9, 1'b0);
        step(1);
        checkOutput("midnight_roll", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        checkPm("pm_24h", 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
